// File: rtl/rotational_lut_fetch_y_pkg.sv
// Shared types, constants and helpers for the rotational-ensemble luma LUT fetch path.
package rot_ens_pkg;

  localparam int Q_MAX  = 6;
  localparam int W_LANE = 11;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ROT_R = 2'd0,
    ROT_L = 2'd1,
    ROT_U = 2'd2,
    ROT_D = 2'd3
  } rot_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Saturating 3-bit quantisation of an 8-bit luma sample (0..Q_MAX).
  function automatic logic [2:0] quant(input logic [7:0] p);
    return (p[7:5] > 3'(Q_MAX)) ? 3'(Q_MAX) : p[7:5];
  endfunction

  // Signed int8 LUT lane scaled by 4 into the W_LANE-bit output format.
  function automatic logic signed [W_LANE-1:0] lane_expand(input logic [7:0] b);
    return {{(W_LANE-10){b[7]}}, b, 2'b00};
  endfunction

endpackage

// File: rtl/rotational_lut_fetch_y_if.sv
// Patch input, SRAM read port and output bundle of the luma LUT fetch block.
interface rotational_lut_fetch_y_if;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [7:0]                              p0, p1, p2, p3;
  logic                                    sram_rd_en;
  logic [rot_ens_pkg::ADDR_W-1:0]          sram_addr;
  logic [31:0]                             sram_rdata;
  logic                                    out_valid;
  logic                                    out_ready;
  logic signed [rot_ens_pkg::W_LANE-1:0]   out1_R, out2_R, out3_R, out4_R;
  logic signed [rot_ens_pkg::W_LANE-1:0]   out1_L, out2_L, out3_L, out4_L;
  logic signed [rot_ens_pkg::W_LANE-1:0]   out1_U, out2_U, out3_U, out4_U;
  logic signed [rot_ens_pkg::W_LANE-1:0]   out1_D, out2_D, out3_D, out4_D;

  // Block side
  modport slave (
    input  in_valid, p0, p1, p2, p3, sram_rdata, out_ready,
    output in_ready, sram_rd_en, sram_addr, out_valid,
    output out1_R, out2_R, out3_R, out4_R, out1_L, out2_L, out3_L, out4_L,
    output out1_U, out2_U, out3_U, out4_U, out1_D, out2_D, out3_D, out4_D
  );

  // Patch source / SRAM / consumer side
  modport master (
    output in_valid, p0, p1, p2, p3, sram_rdata, out_ready,
    input  in_ready, sram_rd_en, sram_addr, out_valid,
    input  out1_R, out2_R, out3_R, out4_R, out1_L, out2_L, out3_L, out4_L,
    input  out1_U, out2_U, out3_U, out4_U, out1_D, out2_D, out3_D, out4_D
  );

endinterface

// File: rtl/rotational_lut_fetch_y_rot_lut_index.sv
// Combinational rotated LUT address: quantise the 2x2 patch, permute per rotation, base-7 index.
module rot_lut_index
  import rot_ens_pkg::*;
#(
  parameter int LUT_BASE = 0
) (
  input  logic [7:0]        p0_i,
  input  logic [7:0]        p1_i,
  input  logic [7:0]        p2_i,
  input  logic [7:0]        p3_i,
  input  rot_e              rot_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [2:0] q [4];
  logic [2:0] a, b, c, d;

  // Quantise, reorder samples for the requested rotation, then form the index.
  always_comb begin
    q[0] = quant(p0_i);
    q[1] = quant(p1_i);
    q[2] = quant(p2_i);
    q[3] = quant(p3_i);
    a = q[0];
    b = q[1];
    c = q[2];
    d = q[3];
    case (rot_i)
      ROT_R: begin a = q[0]; b = q[1]; c = q[2]; d = q[3]; end
      ROT_L: begin a = q[3]; b = q[2]; c = q[1]; d = q[0]; end
      ROT_U: begin a = q[2]; b = q[0]; c = q[3]; d = q[1]; end
      ROT_D: begin a = q[1]; b = q[3]; c = q[0]; d = q[2]; end
      default: ;
    endcase
    addr_o = ADDR_W'(LUT_BASE) + ADDR_W'(a) * 12'd343 + ADDR_W'(b) * 12'd49
           + ADDR_W'(c) * 12'd7 + ADDR_W'(d);
  end

endmodule

// File: rtl/rotational_lut_fetch_y.sv
// Luma LUT fetch front end: accepts a 2x2 patch, issues R/L/U/D SRAM reads,
// unpacks each word into four lanes and presents the 16-value bundle.
module rotational_lut_fetch_y
  import rot_ens_pkg::*;
#(
  parameter int LUT_DEPTH = 3392,
  parameter int LUT_BASE  = 0,
  parameter int RD_LAT    = 1
) (
  input  logic clk,
  input  logic rst,
  rotational_lut_fetch_y_if.slave bus
);

  if (LUT_BASE + 2400 >= LUT_DEPTH) begin : g_bad_base
    $error("LUT_BASE places indices beyond LUT_DEPTH");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("RD_LAT must be 1..3");
  end

  state_e                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     rd_en_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [1:0]               rot_q;
  logic [7:0]               p_q [4];
  logic [RD_LAT-1:0]        tv_q;
  logic [1:0]               tag_q [RD_LAT];
  logic signed [W_LANE-1:0] bank_q [4][4];

  logic [7:0]               sel_p [4];
  rot_e                     sel_rot;
  logic [ADDR_W-1:0]        idx_addr;
  logic                     d_cap;

  // Address source: the live inputs at accept (R read), the stored patch for later reads.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_p   = '{bus.p0, bus.p1, bus.p2, bus.p3};
      sel_rot = ROT_R;
    end else begin
      sel_p   = p_q;
      sel_rot = rot_e'(rot_q + 2'd1);
    end
  end

  rot_lut_index #(.LUT_BASE(LUT_BASE)) u_index (
    .p0_i   (sel_p[0]),
    .p1_i   (sel_p[1]),
    .p2_i   (sel_p[2]),
    .p3_i   (sel_p[3]),
    .rot_i  (sel_rot),
    .addr_o (idx_addr)
  );

  assign d_cap = tv_q[RD_LAT-1] && (tag_q[RD_LAT-1] == 2'(ROT_D));

  // Control FSM; the R read is launched on the accept edge so reads span the 4 ISSUE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      rot_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) p_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            p_q        <= '{bus.p0, bus.p1, bus.p2, bus.p3};
            in_ready_q <= 1'b0;
            rd_en_q    <= 1'b1;
            addr_q     <= idx_addr;
            rot_q      <= 2'(ROT_R);
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rot_q == 2'(ROT_D)) begin
            rd_en_q <= 1'b0;
            state_q <= ST_WAIT;
          end else begin
            rot_q  <= rot_q + 2'd1;
            addr_q <= idx_addr;
          end
        end
        ST_WAIT: begin
          if (d_cap) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Rotation tag pipe, aligned to SRAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tv_q[0]  <= rd_en_q;
      tag_q[0] <= rot_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Unpack each returning word into the bank named by its tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 4; r++)
        for (int unsigned k = 0; k < 4; k++) bank_q[r][k] <= '0;
    end else if (tv_q[RD_LAT-1]) begin
      for (int unsigned k = 0; k < 4; k++)
        bank_q[tag_q[RD_LAT-1]][k] <= lane_expand(bus.sram_rdata[8*k +: 8]);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sram_rd_en = rd_en_q;
  assign bus.sram_addr  = addr_q;

  assign bus.out1_R = bank_q[0][0];
  assign bus.out2_R = bank_q[0][1];
  assign bus.out3_R = bank_q[0][2];
  assign bus.out4_R = bank_q[0][3];
  assign bus.out1_L = bank_q[1][0];
  assign bus.out2_L = bank_q[1][1];
  assign bus.out3_L = bank_q[1][2];
  assign bus.out4_L = bank_q[1][3];
  assign bus.out1_U = bank_q[2][0];
  assign bus.out2_U = bank_q[2][1];
  assign bus.out3_U = bank_q[2][2];
  assign bus.out4_U = bank_q[2][3];
  assign bus.out1_D = bank_q[3][0];
  assign bus.out2_D = bank_q[3][1];
  assign bus.out3_D = bank_q[3][2];
  assign bus.out4_D = bank_q[3][3];

endmodule

// File: tb/tb_rotational_lut_fetch_y.sv
// Directed bench: two instances (RD_LAT=1 base 0, RD_LAT=3 base 100) driven with identical patches.
module tb_rotational_lut_fetch_y;

  localparam int B0 = 0;
  localparam int B1 = 100;
  localparam int L0 = 1;
  localparam int L1 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] pv [4];
  int         mode;
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  rotational_lut_fetch_y_if bus0 ();
  rotational_lut_fetch_y_if bus1 ();

  rotational_lut_fetch_y #(.LUT_DEPTH(3392), .LUT_BASE(B0), .RD_LAT(L0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0));
  rotational_lut_fetch_y #(.LUT_DEPTH(3392), .LUT_BASE(B1), .RD_LAT(L1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  // mode 0: all-zero words, 1: constant 0x7F80FF01, 2: word = address
  function automatic logic [31:0] word_of(input int a, input int m);
    logic [11:0] a12;
    a12 = 12'(a);
    case (m)
      0:       return 32'h0;
      1:       return 32'h7F80FF01;
      default: return {20'h0, a12};
    endcase
  endfunction

  function automatic int expand(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v > 127) v = v - 256;
    return v * 4;
  endfunction

  // SRAM models: data valid RD_LAT cycles after the strobe, garbage otherwise.
  logic [12:0] sp0 [1];
  logic [12:0] sp1 [3];
  always @(posedge clk) sp0[0] <= {bus0.sram_rd_en, bus0.sram_addr};
  always @(posedge clk) begin
    sp1[0] <= {bus1.sram_rd_en, bus1.sram_addr};
    sp1[1] <= sp1[0];
    sp1[2] <= sp1[1];
  end
  assign bus0.sram_rdata = sp0[0][12] ? word_of(int'(sp0[0][11:0]), mode) : 32'hDEADBEEF;
  assign bus1.sram_rdata = sp1[2][12] ? word_of(int'(sp1[2][11:0]), mode) : 32'hDEADBEEF;

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
  assign bus0.p0 = pv[0]; assign bus0.p1 = pv[1]; assign bus0.p2 = pv[2]; assign bus0.p3 = pv[3];
  assign bus1.p0 = pv[0]; assign bus1.p1 = pv[1]; assign bus1.p2 = pv[2]; assign bus1.p3 = pv[3];

  logic              ov [2];
  logic              ir [2];
  logic              rden [2];
  logic [11:0]       addr [2];
  logic signed [10:0] outv [2][16];
  assign ov[0] = bus0.out_valid;   assign ov[1] = bus1.out_valid;
  assign ir[0] = bus0.in_ready;    assign ir[1] = bus1.in_ready;
  assign rden[0] = bus0.sram_rd_en; assign rden[1] = bus1.sram_rd_en;
  assign addr[0] = bus0.sram_addr;  assign addr[1] = bus1.sram_addr;
  always_comb begin
    outv[0] = '{bus0.out1_R, bus0.out2_R, bus0.out3_R, bus0.out4_R,
                bus0.out1_L, bus0.out2_L, bus0.out3_L, bus0.out4_L,
                bus0.out1_U, bus0.out2_U, bus0.out3_U, bus0.out4_U,
                bus0.out1_D, bus0.out2_D, bus0.out3_D, bus0.out4_D};
    outv[1] = '{bus1.out1_R, bus1.out2_R, bus1.out3_R, bus1.out4_R,
                bus1.out1_L, bus1.out2_L, bus1.out3_L, bus1.out4_L,
                bus1.out1_U, bus1.out2_U, bus1.out3_U, bus1.out4_U,
                bus1.out1_D, bus1.out2_D, bus1.out3_D, bus1.out4_D};
  end

  typedef struct {
    logic [7:0] p0, p1, p2, p3;
    int         mode;
    int         ar, al, au, ad;
  } vec_t;

  vec_t vecs [6];

  function automatic int base_of(input int d);
    return (d == 0) ? B0 : B1;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Compare all 16 outputs of instance d against the model for vector v.
  task automatic check_outs(input vec_t v, input int d, input string tag);
    int ea [4];
    ea = '{v.ar, v.al, v.au, v.ad};
    for (int r = 0; r < 4; r++) begin
      logic [31:0] w;
      w = word_of(ea[r] + base_of(d), v.mode);
      for (int k = 0; k < 4; k++)
        check($sformatf("%s d%0d out%0d_%0d", tag, d, k + 1, r), int'(outv[d][r*4+k]),
              expand(w[8*k +: 8]));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d in_ready", tag, d), int'(ir[d]), 1);
      check($sformatf("%s d%0d out_valid", tag, d), int'(ov[d]), 0);
      check($sformatf("%s d%0d rd_en", tag, d), int'(rden[d]), 0);
      check($sformatf("%s d%0d addr", tag, d), int'(addr[d]), 0);
      for (int i = 0; i < 16; i++)
        check($sformatf("%s d%0d out[%0d]", tag, d, i), int'(outv[d][i]), 0);
    end
  endtask

  // Accept one patch and follow both instances for a fixed window, leaving them in DONE.
  task automatic run_vec(input vec_t v, input string tag);
    int ea [4];
    int got_a [2][4];
    int got_n [2];
    int lat [2];
    ea = '{v.ar, v.al, v.au, v.ad};
    got_n = '{0, 0};
    lat = '{-1, -1};
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 4; r++) got_a[d][r] = -1;
    mode = v.mode;
    pv = '{v.p0, v.p1, v.p2, v.p3};
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) check($sformatf("%s d%0d ready pre", tag, d), int'(ir[d]), 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      for (int d = 0; d < 2; d++) begin
        if (rden[d]) begin
          if (got_n[d] < 4) got_a[d][got_n[d]] = int'(addr[d]);
          got_n[d]++;
        end
        if (ov[d] && lat[d] < 0) lat[d] = cyc;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d latency", tag, d), lat[d], 4 + lat_of(d));
      check($sformatf("%s d%0d reads", tag, d), got_n[d], 4);
      for (int r = 0; r < 4; r++)
        check($sformatf("%s d%0d addr%0d", tag, d, r), got_a[d][r], ea[r] + base_of(d));
      check($sformatf("%s d%0d ready busy", tag, d), int'(ir[d]), 0);
      check_outs(v, d, tag);
    end
  endtask

  task automatic release_bundle(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d valid after", tag, d), int'(ov[d]), 0);
      check($sformatf("%s d%0d ready after", tag, d), int'(ir[d]), 1);
    end
  endtask

  // Hold DONE with out_ready low and a stray in_valid pulse in the middle.
  task automatic hold_check(input vec_t v);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      pv = (c == 3) ? '{8'd255, 8'd255, 8'd255, 8'd255} : pv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("hold%0d d%0d valid", c, d), int'(ov[d]), 1);
        check($sformatf("hold%0d d%0d rd_en", c, d), int'(rden[d]), 0);
        check($sformatf("hold%0d d%0d ready", c, d), int'(ir[d]), 0);
        check_outs(v, d, $sformatf("hold%0d", c));
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'd0,   8'd0,   8'd0,   8'd0,   0,    0,    0,    0,    0};
    vecs[1] = '{8'd255, 8'd0,   8'd0,   8'd0,   2, 2058,    6,  294,   42};
    vecs[2] = '{8'd32,  8'd64,  8'd96,  8'd128, 1,  466, 1534, 1108,  892};
    vecs[3] = '{8'd224, 8'd31,  8'd200, 8'd100, 2, 2103, 1329, 2373,  195};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 1, 2400, 2400, 2400, 2400};
    vecs[5] = '{8'd191, 8'd192, 8'd0,   8'd63,  2, 2010,  390,  258, 2142};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pv = '{8'd0, 8'd0, 8'd0, 8'd0};
    mode = 0;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("idle");

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 2) hold_check(vecs[2]);
      release_bundle($sformatf("v%0d rel", i));
    end

    // Reset during WAIT: both instances have reads in flight or partly captured.
    mode = 1;
    pv = '{8'd32, 8'd64, 8'd96, 8'd128};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_state("rst mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check_reset_state($sformatf("post rst%0d", c));
    end

    run_vec(vecs[5], "after rst");
    release_bundle("after rst rel");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
